ft245_sync_tx: RTL and testbench
================================

// Module: ft245_sync_tx
// PURPOSE
// FPGA-side transmit path of the FT245 synchronous-FIFO host interface. Takes one response
// packet (status, address, N data words) from the wishbone master's output side, serializes
// it MSB-first into bytes and writes them to the FTDI chip with the txe_n/wr_n handshake.
// Shares the bidirectional FTDI data bus with the receive path through a request/grant pair.
// Runs on the FTDI clock; any clock crossing is done upstream.
// PARAMETERS
// COUNT_WIDTH  28  width of data_count and the internal word counter
// SIWU_EN      1   1: pulse ftdi_siwu_n low one cycle after the final byte; 0: hold high
// PORTS
// clk            in   1   FTDI 60 MHz clock; all logic on posedge
// rst            in   1   synchronous, active-high
// hdr_valid      in   1   status/address/data_count valid
// hdr_ready      out  1   header accepted (high only in IDLE)
// status         in   32  first word sent
// address        in   32  second word sent
// data_count     in   CW  data words following the header; 0 is treated as 1
// data_valid     in   1   data word valid
// data_ready     out  1   data word consumed this cycle (combinational)
// data           in   32  data word
// bus_req        out  1   request FTDI data bus from the RX/TX arbiter
// bus_grant      in   1   bus granted; RX path has priority, grant may drop between bytes
// ftdi_txe_n     in   1   low: FTDI TX FIFO has space
// ftdi_wr_n      out  1   low: ftdi_data is valid this cycle
// ftdi_data_out  out  8   byte to drive
// ftdi_data_oe   out  1   high: drive ftdi_data (tristate control)
// ftdi_siwu_n    out  1   send-immediate, active low
// busy           out  1   high whenever state != IDLE
// BEHAVIOUR
// - Reset: state IDLE, hdr_ready=1, data_ready=0, bus_req=0, ftdi_wr_n=1, ftdi_data_out=0,
//   ftdi_data_oe=0, ftdi_siwu_n=1, busy=0, counters cleared. Reset mid-packet drops the packet.
// - Byte order: status[31:24..7:0], address[31:24..7:0], then each data word MSB first.
//   Total bytes = 8 + 4*max(data_count,1).
// - Byte consumed: any posedge where ftdi_wr_n==0 and ftdi_txe_n==0. Only then does the
//   shift register advance; otherwise the byte is held unchanged on ftdi_data_out.
// - ftdi_wr_n = ~(state==SEND && byte_valid && bus_grant && !txe_n_q), decoded from registers
//   plus bus_grant; never low in any other state. ftdi_data_oe = bus_grant && state==SEND.
// - States:
//   IDLE: hdr_ready=1. hdr_valid -> latch status, address, count (0->1); load status into
//     shift reg, byte_valid=1; -> REQ.
//   REQ: bus_req=1. bus_grant -> SEND.
//   SEND: bus_req=1. On consume: advance byte index (0..3). On word's last byte: header word 0
//     -> load address; otherwise if words remain and data_valid -> load data, data_ready=1;
//     if words remain and !data_valid -> byte_valid=0 (underrun; wr_n high) and load the first
//     cycle data_valid is seen; if no words remain -> FLUSH. Grant drop: wr_n high, byte held,
//     stay in SEND, bus_req stays high.
//   FLUSH: bus_req=0, ftdi_siwu_n=0 for exactly 1 cycle if SIWU_EN; -> IDLE next cycle.
// - txe_n high stalls indefinitely; no timeout. data_ready never asserts outside SEND.
// - Word counter decrements on each data word load; width COUNT_WIDTH, no wrap (max 2^CW-1).
// - Simultaneous hdr_valid during busy: ignored (hdr_ready=0); upstream must hold it.
// - Throughput: one byte per cycle with txe_n low, grant held and data_valid always high.
// TESTING
// 1 hdr status=0xCD000001 addr=0x01000000 count=1, data=0x12345678, txe_n=0 -> 12 bytes
//   CD 00 00 01 01 00 00 00 12 34 56 78 on 12 consecutive wr_n-low cycles, siwu_n low 1 cycle.
// 2 count=0 -> identical framing to count=1 (12 bytes, one data_ready pulse).
// 3 count=3, txe_n high for 5 cycles at byte 6 -> wr_n high, byte 6 held; resumes, 20 bytes.
// 4 data_valid low 4 cycles before word 2 -> wr_n high during gap, no duplicate/lost byte.
// 5 bus_grant dropped 3 cycles mid-word -> oe=0, wr_n=1, byte held; stream completes intact.
// 6 rst asserted at byte 9 -> next cycle all outputs at reset values; new packet sends cleanly.

Source files
------------

// File: rtl/ft245_sync_tx.sv
`default_nettype none
// ============================================================================
// Module      : ft245_sync_tx
// Description : Transmit path of the FT245 synchronous-FIFO host interface.
//               Serializes one response packet (status, address, N data
//               words) MSB-first into bytes and writes them to the FTDI chip
//               using the txe_n / wr_n handshake. The shared FTDI data bus is
//               obtained from the RX/TX arbiter through bus_req / bus_grant.
// Revision    : 1.0 - initial release
// ============================================================================
module ft245_sync_tx #(
    parameter int   COUNT_WIDTH = 28,
    parameter logic SIWU_EN     = 1'b1
) (
    input  logic                   clk,
    input  logic                   rst,
    // packet header
    input  logic                   hdr_valid,
    output logic                   hdr_ready,
    input  logic [31:0]            status,
    input  logic [31:0]            address,
    input  logic [COUNT_WIDTH-1:0] data_count,
    // data words
    input  logic                   data_valid,
    output logic                   data_ready,
    input  logic [31:0]            data,
    // bus arbitration
    output logic                   bus_req,
    input  logic                   bus_grant,
    // FTDI side
    input  logic                   ftdi_txe_n,
    output logic                   ftdi_wr_n,
    output logic [7:0]             ftdi_data_out,
    output logic                   ftdi_data_oe,
    output logic                   ftdi_siwu_n,
    output logic                   busy
);

    localparam logic [COUNT_WIDTH-1:0] c_ONE = {{(COUNT_WIDTH-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_REQ   = 2'd1,
        S_SEND  = 2'd2,
        S_FLUSH = 2'd3
    } state_t;

    state_t                   r_state;
    state_t                   w_state_nxt;

    logic [31:0]              r_shift;       // current word, top byte is on the bus
    logic [31:0]              r_addr;        // address word waits here while status is sent
    logic [COUNT_WIDTH-1:0]   r_words_left;  // data words not yet loaded
    logic [1:0]               r_byte_idx;    // byte position inside the current word
    logic                     r_byte_valid;  // shift register holds an unsent byte
    logic                     r_hdr_phase;   // status word is the one being sent
    logic                     r_txe_n_q;     // registered FIFO-full flag

    logic                     w_send;
    logic                     w_consume;
    logic                     w_word_end;
    logic                     w_words_rem;
    logic                     w_load_data;
    logic                     w_last;

    // Byte handshake decode: wr_n comes only from registers plus the grant,
    // and a byte counts as written only when the FIFO also had room.
    always_comb begin
        w_send      = (r_state == S_SEND);
        ftdi_wr_n   = ~(w_send && r_byte_valid && bus_grant && !r_txe_n_q);
        w_consume   = !ftdi_wr_n && !ftdi_txe_n;
        w_word_end  = w_consume && (r_byte_idx == 2'd3);
        w_words_rem = (r_words_left != '0);
        // A data word is taken either at the end of a non-status word or,
        // after an underrun, the first cycle data_valid shows up again.
        w_load_data = w_send && data_valid && w_words_rem &&
                      ((w_word_end && !r_hdr_phase) || !r_byte_valid);
        w_last      = w_word_end && !r_hdr_phase && !w_words_rem;
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state and control outputs.
    always_comb begin
        w_state_nxt  = r_state;
        hdr_ready    = 1'b0;
        bus_req      = 1'b0;
        ftdi_data_oe = 1'b0;
        ftdi_siwu_n  = 1'b1;
        busy         = 1'b1;
        data_ready   = 1'b0;
        case (r_state)
            S_IDLE: begin
                hdr_ready = 1'b1;
                busy      = 1'b0;
                if (hdr_valid) begin
                    w_state_nxt = S_REQ;
                end
            end
            S_REQ: begin
                bus_req = 1'b1;
                if (bus_grant) begin
                    w_state_nxt = S_SEND;
                end
            end
            S_SEND: begin
                bus_req      = 1'b1;
                ftdi_data_oe = bus_grant;
                data_ready   = w_load_data;
                if (w_last) begin
                    w_state_nxt = S_FLUSH;
                end
            end
            S_FLUSH: begin
                ftdi_siwu_n = ~SIWU_EN;
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    assign ftdi_data_out = r_shift[31:24];

    // Datapath: header latch, byte shifting, word loading and underrun tracking.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_shift      <= '0;
            r_addr       <= '0;
            r_words_left <= '0;
            r_byte_idx   <= '0;
            r_byte_valid <= 1'b0;
            r_hdr_phase  <= 1'b0;
            r_txe_n_q    <= 1'b1;
        end else begin
            r_txe_n_q <= ftdi_txe_n;
            case (r_state)
                S_IDLE: begin
                    if (hdr_valid) begin
                        r_shift      <= status;
                        r_addr       <= address;
                        // A zero count still carries one data word.
                        r_words_left <= (data_count == '0) ? c_ONE : data_count;
                        r_byte_idx   <= 2'd0;
                        r_byte_valid <= 1'b1;
                        r_hdr_phase  <= 1'b1;
                    end
                end
                S_SEND: begin
                    if (w_load_data) begin
                        r_shift      <= data;
                        r_words_left <= r_words_left - c_ONE;
                        r_byte_idx   <= 2'd0;
                        r_byte_valid <= 1'b1;
                    end else if (w_consume) begin
                        if (r_byte_idx != 2'd3) begin
                            r_shift    <= {r_shift[23:0], 8'h00};
                            r_byte_idx <= r_byte_idx + 2'd1;
                        end else begin
                            r_byte_idx <= 2'd0;
                            if (r_hdr_phase) begin
                                r_shift     <= r_addr;
                                r_hdr_phase <= 1'b0;
                            end else begin
                                // Either the packet is finished or the next
                                // data word is late; hold wr_n high until then.
                                r_byte_valid <= 1'b0;
                            end
                        end
                    end
                end
                S_FLUSH: begin
                    r_byte_valid <= 1'b0;
                end
                default: begin
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_ft245_sync_tx.sv
`default_nettype none
// ============================================================================
// Module      : tb_ft245_sync_tx
// Description : Self-checking bench for ft245_sync_tx. Expected byte stream is
//               built from the packet contents; directed and random packets.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ft245_sync_tx;
    localparam int CW = 28;

    logic          clk = 1'b0;
    logic          rst;
    logic          hdr_valid;
    logic          hdr_ready;
    logic [31:0]   status;
    logic [31:0]   address;
    logic [CW-1:0] data_count;
    logic          data_valid;
    logic          data_ready;
    logic [31:0]   data;
    logic          bus_req;
    logic          bus_grant;
    logic          ftdi_txe_n;
    logic          ftdi_wr_n;
    logic [7:0]    ftdi_data_out;
    logic          ftdi_data_oe;
    logic          ftdi_siwu_n;
    logic          busy;

    ft245_sync_tx #(.COUNT_WIDTH(CW), .SIWU_EN(1'b1)) dut (
        .clk(clk), .rst(rst),
        .hdr_valid(hdr_valid), .hdr_ready(hdr_ready),
        .status(status), .address(address), .data_count(data_count),
        .data_valid(data_valid), .data_ready(data_ready), .data(data),
        .bus_req(bus_req), .bus_grant(bus_grant),
        .ftdi_txe_n(ftdi_txe_n), .ftdi_wr_n(ftdi_wr_n),
        .ftdi_data_out(ftdi_data_out), .ftdi_data_oe(ftdi_data_oe),
        .ftdi_siwu_n(ftdi_siwu_n), .busy(busy)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    logic [7:0]  q_exp[$];
    logic [31:0] q_data[$];
    int nbytes, words_taken, siwu_cnt, siwu_cyc, first_cyc, last_cyc;
    int cyc = 0;
    int pct_txe = 0, pct_gnt = 0, pct_dv = 0;
    int txe_at = -1, txe_len = 0, gnt_at = -1, gnt_len = 0, dv_at = -1, dv_len = 0;
    int txe_hold = 0, gnt_hold = 0, dv_hold = 0;
    bit prev_txe = 1'b1;
    bit hdr_acc  = 1'b0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock: drive inputs after the falling edge, then sample what the
    // DUT will present at the next rising edge.
    task automatic cycle();
        bit forced;
        @(negedge clk);
        if (hdr_acc) hdr_valid = 1'b0;
        forced     = (txe_hold > 0) || (gnt_hold > 0);
        ftdi_txe_n = (txe_hold > 0) || ($urandom_range(0, 99) < pct_txe);
        bus_grant  = bus_req && (gnt_hold == 0) && !($urandom_range(0, 99) < pct_gnt);
        data_valid = (q_data.size() > 0) && (dv_hold == 0) && !($urandom_range(0, 99) < pct_dv);
        data       = (q_data.size() > 0) ? q_data[0] : $urandom;
        if (txe_hold > 0) txe_hold--;
        if (gnt_hold > 0) gnt_hold--;
        if (dv_hold > 0)  dv_hold--;
        #1;
        if (hdr_valid && hdr_ready) hdr_acc = 1'b1;
        chk("hdr_ready_only_idle", {31'd0, hdr_ready}, {31'd0, !busy});
        chk("oe_without_grant", {31'd0, ftdi_data_oe & ~bus_grant}, 32'd0);
        if (!ftdi_wr_n)
            chk("wr_low_needs_grant_oe_txeq", {29'd0, bus_grant, ftdi_data_oe, prev_txe}, 32'd6);
        if (forced && q_exp.size() > 0)
            chk("held_byte", {24'd0, ftdi_data_out}, {24'd0, q_exp[0]});
        if (!ftdi_wr_n && !ftdi_txe_n) begin
            if (q_exp.size() == 0) begin
                chk("extra_byte", {24'd0, ftdi_data_out}, 32'hFFFF_FFFF);
            end else begin
                chk("byte", {24'd0, ftdi_data_out}, {24'd0, q_exp.pop_front()});
            end
            nbytes++;
            if (first_cyc < 0) first_cyc = cyc;
            last_cyc = cyc;
            if (nbytes == txe_at) txe_hold = txe_len;
            if (nbytes == gnt_at) gnt_hold = gnt_len;
            if (nbytes == dv_at)  dv_hold  = dv_len;
        end
        if (data_ready) begin
            chk("data_ready_legal", {29'd0, data_valid, busy, q_data.size() > 0}, 32'd7);
            if (q_data.size() > 0) void'(q_data.pop_front());
            words_taken++;
        end
        if (!ftdi_siwu_n) begin
            siwu_cnt++;
            siwu_cyc = cyc;
        end
        prev_txe = rst ? 1'b1 : ftdi_txe_n;
        cyc++;
    endtask

    // Build the expected stream for one packet and run it to completion
    // (or until stop_at bytes have been written).
    task automatic run_pkt(input logic [31:0] st, input logic [31:0] ad,
                           input logic [CW-1:0] cnt, input logic [31:0] w0,
                           input int stop_at, input bit check_timing);
        int  n;
        bit  done;
        logic [31:0] w;
        n = (cnt == 0) ? 1 : int'(cnt);
        q_exp.delete();
        q_data.delete();
        for (int b = 3; b >= 0; b--) q_exp.push_back(st[b*8 +: 8]);
        for (int b = 3; b >= 0; b--) q_exp.push_back(ad[b*8 +: 8]);
        for (int i = 0; i < n; i++) begin
            w = (i == 0) ? w0 : $urandom;
            q_data.push_back(w);
            for (int b = 3; b >= 0; b--) q_exp.push_back(w[b*8 +: 8]);
        end
        nbytes = 0; words_taken = 0; siwu_cnt = 0; siwu_cyc = -1;
        first_cyc = -1; last_cyc = -1; hdr_acc = 1'b0; done = 1'b0;
        status = st; address = ad; data_count = cnt; hdr_valid = 1'b1;
        for (int k = 0; k < 4000; k++) begin
            cycle();
            if (stop_at > 0 && nbytes == stop_at) return;
            if (hdr_acc && q_exp.size() == 0 && !busy) begin
                done = 1'b1;
                break;
            end
        end
        hdr_valid = 1'b0;
        chk("pkt_timeout", {31'd0, done}, 32'd1);
        chk("bytes_left", q_exp.size(), 32'd0);
        chk("words_taken", words_taken, n);
        chk("siwu_pulses", siwu_cnt, 32'd1);
        chk("siwu_after_last", siwu_cyc, last_cyc + 1);
        if (check_timing) chk("consecutive_bytes", last_cyc - first_cyc, 8 + 4 * n - 1);
        txe_at = -1; gnt_at = -1; dv_at = -1;
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk(tag, {24'd0, hdr_ready, data_ready, bus_req, ftdi_wr_n,
                  ftdi_data_oe, ftdi_siwu_n, busy, 1'b0},
                 {24'd0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0});
        chk({tag, "_data"}, {24'd0, ftdi_data_out}, 32'd0);
    endtask

    initial begin
        rst = 1'b1; hdr_valid = 1'b0; status = '0; address = '0; data_count = '0;
        data_valid = 1'b0; data = '0; bus_grant = 1'b0; ftdi_txe_n = 1'b1;
        @(negedge clk);
        @(negedge clk);
        #1;
        chk_reset_outputs("reset_state");
        rst = 1'b0;
        prev_txe = 1'b1;

        // Basic packet, ideal flow: 12 back-to-back bytes.
        run_pkt(32'hCD00_0001, 32'h0100_0000, 28'd1, 32'h1234_5678, 0, 1'b1);
        // Zero count frames like a count of one.
        run_pkt(32'hA5A5_0002, 32'h0000_0040, 28'd0, 32'hDEAD_BEEF, 0, 1'b1);
        // FIFO full for 5 cycles at byte 6.
        txe_at = 6; txe_len = 5;
        run_pkt(32'h1111_2222, 32'h3333_4444, 28'd3, 32'h5566_7788, 0, 1'b0);
        chk("stall_byte_count", nbytes, 32'd20);
        // Data word 2 arrives late.
        dv_at = 10; dv_len = 6;
        run_pkt(32'h0BAD_F00D, 32'hCAFE_0001, 28'd3, 32'h0102_0304, 0, 1'b0);
        // Grant withdrawn for 3 cycles in the middle of a word.
        gnt_at = 9; gnt_len = 3;
        run_pkt(32'h7777_8888, 32'h9999_AAAA, 28'd2, 32'hBBCC_DDEE, 0, 1'b0);

        // Reset in the middle of a packet.
        run_pkt(32'hF0F0_F0F0, 32'h0F0F_0F0F, 28'd2, 32'h1357_9BDF, 9, 1'b0);
        @(negedge clk);
        rst = 1'b1; hdr_valid = 1'b0; bus_grant = 1'b0; data_valid = 1'b1; ftdi_txe_n = 1'b0;
        @(negedge clk);
        rst = 1'b0; bus_grant = 1'b0;
        #1;
        chk_reset_outputs("after_mid_reset");
        prev_txe = 1'b1;
        q_exp.delete();
        q_data.delete();
        run_pkt(32'h2468_ACE0, 32'h1122_3344, 28'd1, 32'h5555_AAAA, 0, 1'b1);

        // Random traffic with random stalls, grant drops and data gaps.
        pct_txe = 25; pct_gnt = 15; pct_dv = 25;
        for (int p = 0; p < 10; p++) begin
            run_pkt($urandom, $urandom, CW'($urandom_range(0, 5)), $urandom, 0, 1'b0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
`default_nettype wire
